frontend_uop_queue: RTL and testbench
=====================================

FRONTEND_UOP_QUEUE -- requirements
Module: frontend_uop_queue

Interface
REQ-001 Parameter FETCH_WIDTH, default 4: micro-op lanes per bundle.
REQ-002 Parameter UOP_W, default 24: bits per micro-op; bits [UOP_W-1:UOP_W-3] are the op class.
REQ-003 Parameter DEPTH, default 4: bundle slots; power of two, >=2.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 wakeup  in  1  resume issue from SLEEP.
REQ-007 flush  in  1  discard all queued bundles.
REQ-008 in_uops  in  FETCH_WIDTH*UOP_W  incoming bundle, lane g at [g*UOP_W +: UOP_W].
REQ-009 in_mask  in  FETCH_WIDTH  per-lane valid of incoming bundle.
REQ-010 in_valid  in  1  incoming bundle offered.
REQ-011 in_ready  out  1  queue accepts bundle.
REQ-012 out_uops  out  FETCH_WIDTH*UOP_W  head bundle to decoder.
REQ-013 out_mask  out  FETCH_WIDTH  per-lane valid of head bundle after terminator truncation.
REQ-014 out_valid  out  1  head bundle offered.
REQ-015 out_ready  in  1  decoder consumes bundle.
REQ-016 count  out  $clog2(DEPTH+1)  stored bundles.
REQ-017 running  out  1  state is RUN.

Function
REQ-018 Circular buffer of DEPTH bundles (uops+mask), read/write pointers wrap modulo DEPTH; count from 0 to DEPTH.
REQ-019 in_ready = (count < DEPTH) & ~flush; no same-cycle enqueue-on-dequeue when full.
REQ-020 Enqueue on in_valid & in_ready; bundle with in_mask == 0 is accepted but not stored (count, pointers unchanged).
REQ-021 Lane g is a terminator when mask bit g set and op class == 3'b111.
REQ-022 out_uops = head slot uops; out_mask = head mask with all lanes above the lowest terminator lane cleared.
REQ-023 out_valid = (count != 0) & running & ~flush; dequeue on out_valid & out_ready.
REQ-024 Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
REQ-025 States RUN, SLEEP; running = (state == RUN).
REQ-026 RUN -> SLEEP next cycle when a dequeued bundle contains a terminator and wakeup is low; wakeup high that cycle keeps RUN.
REQ-027 SLEEP -> RUN next cycle when wakeup high; wakeup in RUN has no effect.
REQ-028 Enqueue continues in SLEEP; only dequeue is blocked.
REQ-029 flush: next cycle count = 0, pointers = 0, state = SLEEP unless wakeup high (then RUN); no handshake completes in the flush cycle.
REQ-030 Zero-latency pass-through not provided: enqueued bundle is visible on out_* no earlier than the following cycle.
REQ-031 Storage contents carry no reset; only pointers, count, and state reset.

Reset
REQ-032 rst high on a rising edge sets count = 0, pointers = 0, state = RUN; rst dominates flush, wakeup, and handshakes.
REQ-033 Outputs after reset: in_ready = 1, out_valid = 0, count = 0, running = 1; out_uops/out_mask undefined until first enqueue.
REQ-034 rst asserted mid-operation discards all queued bundles; no dequeue completes in that cycle.

Verification
REQ-035 Fill: DEPTH=4, out_ready=0, 5 valid bundles, masks 4'hF -> count 1,2,3,4; 5th refused (in_ready=0); drain returns bundles in order.
REQ-036 Terminator: bundle with lane 1 class 3'b111, mask 4'hF dequeued -> out_mask = 4'b0011, running = 0 next cycle, out_valid = 0 despite count = 2.
REQ-037 Wakeup: in SLEEP with count = 2, pulse wakeup -> running = 1 and out_valid = 1 next cycle; wakeup with terminator dequeue in same cycle -> running stays 1.
REQ-038 Full concurrent: count = 3, in_valid = out_valid = out_ready = 1 for 10 cycles -> count stays 3, pointers wrap, FIFO order preserved.
REQ-039 Flush: count = 3, flush with in_valid = out_ready = 1 -> no handshake, count = 0, running = 0 next cycle; same with wakeup -> running = 1.
REQ-040 Empty mask and reset: in_mask = 0 accepted with count unchanged; rst at count = 4 in SLEEP -> count = 0, running = 1, in_ready = 1.

Source files
------------

// File: rtl/frontend_uop_queue.sv
// Micro-op bundle queue between fetch and decode, with terminator-driven sleep.
// Latency: a bundle is visible on out_* one cycle after its enqueue.
// Backpressure: in_ready drops when full or flushing; out_valid is held low in SLEEP or while flushing.
module frontend_uop_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int UOP_W       = 24,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wakeup,
    input  logic                         flush,
    input  logic [FETCH_WIDTH*UOP_W-1:0] in_uops,
    input  logic [FETCH_WIDTH-1:0]       in_mask,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [FETCH_WIDTH*UOP_W-1:0] out_uops,
    output logic [FETCH_WIDTH-1:0]       out_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         running
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [2:0] TERM_CLASS = 3'b111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } state_e;

    // Bundle storage; contents are only meaningful between write and read pointer.
    logic [FETCH_WIDTH*UOP_W-1:0] uops_mem [DEPTH];
    logic [FETCH_WIDTH-1:0]       mask_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;

    logic                         enq_hs;
    logic                         deq_hs;
    logic                         store_en;
    logic [FETCH_WIDTH*UOP_W-1:0] head_uops;
    logic [FETCH_WIDTH-1:0]       head_mask;
    logic [FETCH_WIDTH-1:0]       head_term;
    logic [FETCH_WIDTH-1:0]       trunc_mask;
    logic                         head_has_term;

    assign running   = (state_q == ST_RUN);
    assign count     = count_q;
    assign in_ready  = (count_q < DEPTH_C) & ~flush;
    assign out_valid = (count_q != '0) & running & ~flush;

    assign enq_hs   = in_valid & in_ready;
    assign deq_hs   = out_valid & out_ready;
    // An all-lanes-empty bundle is acknowledged but leaves nothing to decode.
    assign store_en = enq_hs & (in_mask != '0);

    assign head_uops = uops_mem[rd_ptr_q];
    assign head_mask = mask_mem[rd_ptr_q];

    // Find terminator lanes and drop every valid lane above the first one.
    always_comb begin
        logic seen;
        head_term  = '0;
        trunc_mask = '0;
        seen       = 1'b0;
        for (int g = 0; g < FETCH_WIDTH; g++) begin
            head_term[g]  = head_mask[g] &
                            (head_uops[g*UOP_W + UOP_W - 3 +: 3] == TERM_CLASS);
            trunc_mask[g] = head_mask[g] & ~seen;
            seen          = seen | head_term[g];
        end
    end

    assign head_has_term = |head_term;
    assign out_uops      = head_uops;
    assign out_mask      = trunc_mask;

    // Write the accepted bundle into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (store_en) begin
            uops_mem[wr_ptr_q] <= in_uops;
            mask_mem[wr_ptr_q] <= in_mask;
        end
    end

    // Next pointers and occupancy from the two handshakes; flush empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq_hs) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({store_en, deq_hs})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // RUN/SLEEP transitions: consuming a terminator sleeps unless wakeup overrides.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = wakeup ? ST_RUN : ST_SLEEP;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (deq_hs && head_has_term && !wakeup) begin
                        state_d = ST_SLEEP;
                    end
                end
                ST_SLEEP: begin
                    if (wakeup) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_frontend_uop_queue.sv
// Directed bench for frontend_uop_queue with a bundle scoreboard and a RUN/SLEEP model.
// Each step drives inputs, checks handshakes before the edge and occupancy/state after it.
// Expected output bundles are queued at enqueue time and compared at dequeue time.
module tb_frontend_uop_queue;

    localparam int FW = 4;
    localparam int UW = 24;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wakeup;
    logic          flush;
    logic [FW*UW-1:0] in_uops;
    logic [FW-1:0] in_mask;
    logic          in_valid;
    logic          in_ready;
    logic [FW*UW-1:0] out_uops;
    logic [FW-1:0] out_mask;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;
    logic          running;

    typedef struct {
        logic [FW*UW-1:0] uops;
        logic [FW-1:0]    mask;
        bit               term;
    } exp_t;

    exp_t sb[$];
    bit   m_run;
    int   n_chk;
    int   n_fail;

    frontend_uop_queue #(.FETCH_WIDTH(FW), .UOP_W(UW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .wakeup    (wakeup),
        .flush     (flush),
        .in_uops   (in_uops),
        .in_mask   (in_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_uops  (out_uops),
        .out_mask  (out_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane g gets a recognisable payload; class is g (never 7) unless g is the terminator lane.
    function automatic logic [FW*UW-1:0] mk(input int tag, input int term_lane);
        logic [FW*UW-1:0] b;
        b = '0;
        for (int g = 0; g < FW; g++) begin
            b[g*UW +: UW] = {(g == term_lane) ? 3'b111 : 3'(g), 21'(tag * 16 + g)};
        end
        return b;
    endfunction

    // Index of the lowest valid lane whose class is 7, or -1.
    function automatic int first_term(input logic [FW*UW-1:0] u, input logic [FW-1:0] m);
        for (int g = 0; g < FW; g++) begin
            if (m[g] && u[g*UW + 21 +: 3] == 3'b111) return g;
        end
        return -1;
    endfunction

    // One clock: check handshakes, update the model, advance, check occupancy and state.
    task automatic cycle();
        bit   exp_ir, exp_ov, deq, enq, term;
        int   lt;
        exp_t e;
        #1;
        exp_ir = (sb.size() < DP) && !flush;
        exp_ov = (sb.size() != 0) && m_run && !flush;
        deq    = 1'b0;
        term   = 1'b0;
        if (!rst) begin
            chk("in_ready", 128'(in_ready), 128'(exp_ir));
            chk("out_valid", 128'(out_valid), 128'(exp_ov));
            deq = exp_ov && out_ready;
            enq = exp_ir && in_valid;
            if (deq) begin
                e = sb.pop_front();
                chk("out_uops", 128'(out_uops), 128'(e.uops));
                chk("out_mask", 128'(out_mask), 128'(e.mask));
                term = e.term;
            end
            if (enq && in_mask != '0) begin
                lt     = first_term(in_uops, in_mask);
                e.uops = in_uops;
                e.mask = (lt < 0) ? in_mask : (in_mask & 4'((2 << lt) - 1));
                e.term = (lt >= 0);
                sb.push_back(e);
            end
        end
        if (rst) begin
            sb.delete();
            m_run = 1'b1;
        end else if (flush) begin
            sb.delete();
            m_run = wakeup;
        end else if (m_run && deq && term && !wakeup) begin
            m_run = 1'b0;
        end else if (!m_run && wakeup) begin
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("count", 128'(count), 128'(sb.size()));
        chk("running", 128'(running), 128'(m_run));
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_mask  = '0;
        in_uops  = '0;
    endtask

    task automatic push(input int tag, input int term_lane, input logic [FW-1:0] m);
        in_valid = 1'b1;
        in_uops  = mk(tag, term_lane);
        in_mask  = m;
        cycle();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        m_run = 1'b1;
        rst = 1'b1;
        wakeup = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_running", 128'(running), 128'(1));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));

        // Fill to capacity; the fifth bundle is refused.
        for (int i = 0; i < 5; i++) push(i, -1, 4'hF);
        chk("fill_full", 128'(count), 128'(4));
        idle_in();
        out_ready = 1'b1;
        repeat (4) cycle();
        out_ready = 1'b0;

        // Terminator in lane 1 truncates to 4'b0011 and puts the queue to sleep.
        push(10, 1, 4'hF);
        push(11, -1, 4'hF);
        push(12, -1, 4'hF);
        idle_in();
        out_ready = 1'b1;
        cycle();
        #1;
        chk("sleep_blocks", 128'(out_valid), 128'(0));
        chk("sleep_count", 128'(count), 128'(2));
        cycle();

        // Wakeup pulse resumes issue.
        out_ready = 1'b0;
        wakeup = 1'b1;
        cycle();
        wakeup = 1'b0;
        #1;
        chk("wake_out_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        repeat (2) cycle();
        out_ready = 1'b0;

        // Terminator consumed with wakeup held stays in RUN; partial mask 4'b1101 -> 4'b0101.
        push(20, 2, 4'b1101);
        // A class-7 lane that is masked off is not a terminator.
        push(21, 0, 4'b1110);
        idle_in();
        out_ready = 1'b1;
        wakeup = 1'b1;
        cycle();
        wakeup = 1'b0;
        cycle();
        chk("no_false_term", 128'(running), 128'(1));
        out_ready = 1'b0;

        // Sustained enqueue+dequeue at count 3 wraps both pointers.
        for (int i = 0; i < 3; i++) push(30 + i, -1, 4'hF);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(40 + i, -1, 4'hF);
        chk("concurrent_count", 128'(count), 128'(3));

        // Flush with both sides requesting: nothing transfers, queue empties, sleeps.
        in_valid = 1'b1;
        in_uops = mk(60, -1);
        in_mask = 4'hF;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        out_ready = 1'b0;
        // Enqueue keeps working while asleep.
        for (int i = 0; i < 3; i++) push(61 + i, -1, 4'hF);
        // Flush with wakeup returns straight to RUN.
        flush = 1'b1;
        wakeup = 1'b1;
        cycle();
        flush = 1'b0;
        wakeup = 1'b0;
        chk("flush_wake_running", 128'(running), 128'(1));

        // Empty-mask bundle is accepted but not stored.
        push(70, -1, 4'hF);
        push(71, -1, 4'hF);
        push(72, -1, 4'h0);
        chk("empty_mask_count", 128'(count), 128'(2));
        idle_in();
        out_ready = 1'b1;
        repeat (2) cycle();

        // Go to SLEEP, fill to 4, then reset with traffic pending.
        out_ready = 1'b0;
        push(80, 3, 4'hF);
        idle_in();
        out_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) push(81 + i, -1, 4'hF);
        chk("pre_rst_count", 128'(count), 128'(4));
        chk("pre_rst_running", 128'(running), 128'(0));
        rst = 1'b1;
        wakeup = 1'b0;
        cycle();
        rst = 1'b0;
        idle_in();
        out_ready = 1'b0;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        chk("post_rst_out_valid", 128'(out_valid), 128'(0));
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
